uart_readback_tx: RTL and testbench

//  Serialises register read-back nibbles (data_out / data_out_valid, OR-ed from the

---
 rtl/uart_readback_tx.sv | 145 ++++++++++++++
 tb/tb_uart_readback_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_readback_tx.sv
// Serialises tagged read-back nibbles as 8N1 UART bytes {PREFIX, nibble}, LSB first,
// with a small FIFO so back-to-back read-backs are queued instead of lost.
module uart_readback_tx #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] PREFIX     = 4'hA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  input  logic       clr_ovf,
  output logic       Tx,
  output logic       busy,
  output logic       ovf
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);
  // The FSM takes the head in the same cycle it leaves IDLE, freeing a slot for a push.
  assign pop   = (state == IDLE) && !empty;
  assign push  = data_valid && (!full || pop);
  assign drop  = data_valid && full && !pop;
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      Tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (!empty) begin
            shift <= {PREFIX, mem[rd_ptr]};
            timer <= '0;
            state <= START;
            Tx    <= 1'b0;
          end
        end
        START: begin
          if (timer == TIMER_MAX) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= DATA;
            Tx      <= shift[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == TIMER_MAX) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              Tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              Tx      <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          Tx <= 1'b1;
          if (timer == TIMER_MAX) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_readback_tx.sv
// Bench for uart_readback_tx: timestamp-based line model, serial receiver and
// directed scenarios with literal byte expectations.
module tb_uart_readback_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam logic [3:0] PFX = 4'hA;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       data_valid;
  logic       clr_ovf;
  logic       Tx;
  logic       busy;
  logic       ovf;

  int vectors = 0;
  int miscompares = 0;

  uart_readback_tx #(
    .CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH), .PREFIX(PFX)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .clr_ovf(clr_ovf), .Tx(Tx), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Line model: frames are described by their start edge; bit k of a frame
  // occupies edges [fs + k*CPB, fs + (k+1)*CPB).
  int         cyc = 0;
  int         fs = 0;
  bit         in_frame = 0;
  bit         was_active;
  bit         dropped;
  int         k;
  logic [7:0] cur = 8'h00;
  logic [7:0] mq[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      mq.delete();
      in_frame = 0;
      m_ovf = 1'b0;
      m_tx = 1'b1;
      m_busy = 1'b0;
    end else begin
      cyc++;
      was_active = in_frame;
      if (in_frame && (cyc - fs >= 10 * CPB)) in_frame = 0;
      if (!was_active && mq.size() > 0) begin
        cur = mq.pop_front();
        fs = cyc;
        in_frame = 1;
      end
      dropped = 0;
      if (data_valid) begin
        if (mq.size() < DEPTH) mq.push_back({PFX, data_in});
        else dropped = 1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_tx = 1'b1;
      if (in_frame) begin
        k = (cyc - fs) / CPB;
        if (k == 0) m_tx = 1'b0;
        else if (k <= 8) m_tx = cur[k-1];
      end
      m_busy = in_frame || (mq.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_tx", Tx, m_tx);
      chk("model_busy", busy, m_busy);
      chk("model_ovf", ovf, m_ovf);
    end
  end

  // Serial receiver sampling mid-bit; completed bytes go to rx_q.
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (Tx == 1'b0) begin
        rx_busy = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB == CPB / 2) && (rx_cnt < 9 * CPB)) rx_byte[rx_cnt / CPB - 1] = Tx;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        chk("rx_stop_bit", Tx, 1);
        rx_q.push_back(rx_byte);
        rx_busy = 0;
      end
    end
  end

  task automatic expect_byte(input string name, input logic [7:0] e);
    logic [7:0] b;
    if (rx_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no byte expected %02h", name, e);
    end else begin
      b = rx_q.pop_front();
      chk(name, b, e);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || rx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeout_fail(name);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idle_bad;
    rst = 1'b1;
    data_in = 4'h0;
    data_valid = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_tx", Tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: single byte 0xA5, Tx falls two edges after the strobe cycle
    data_in = 4'h5;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("t1_tx_still_high", Tx, 1);
    chk("t1_busy_on", busy, 1);
    @(negedge clk);
    chk("t1_tx_fall", Tx, 0);
    wait_idle("t1_idle");
    expect_byte("t1_byte", 8'hA5);
    chk("t1_busy_off", busy, 0);
    chk("t1_ovf", ovf, 0);

    // 2: burst of four
    for (int i = 1; i <= 4; i++) begin
      data_in = 4'(i);
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    wait_idle("t2_idle");
    expect_byte("t2_byte0", 8'hA1);
    expect_byte("t2_byte1", 8'hA2);
    expect_byte("t2_byte2", 8'hA3);
    expect_byte("t2_byte3", 8'hA4);
    chk("t2_ovf", ovf, 0);

    // 3: overflow; clear on the dropping cycle must lose to the set
    for (int i = 0; i <= 5; i++) begin
      data_in = 4'(i);
      data_valid = 1'b1;
      clr_ovf = (i == 5);
      @(negedge clk);
    end
    data_valid = 1'b0;
    clr_ovf = 1'b0;
    chk("t3_ovf_set_wins", ovf, 1);
    wait_idle("t3_idle");
    expect_byte("t3_byte0", 8'hA0);
    expect_byte("t3_byte1", 8'hA1);
    expect_byte("t3_byte2", 8'hA2);
    expect_byte("t3_byte3", 8'hA3);
    expect_byte("t3_byte4", 8'hA4);
    chk("t3_no_extra", rx_q.size(), 0);
    chk("t3_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", ovf, 0);

    // 4: push on the pop edge while full
    for (int i = 6; i <= 10; i++) begin
      data_in = 4'(i);
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    n = 0;
    while (!(!in_frame && mq.size() == DEPTH) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout_fail("t4_wait_pop");
    chk("t4_full_busy", busy, 1);
    data_in = 4'hB;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("t4_no_ovf", ovf, 0);
    wait_idle("t4_idle");
    expect_byte("t4_byte0", 8'hA6);
    expect_byte("t4_byte1", 8'hA7);
    expect_byte("t4_byte2", 8'hA8);
    expect_byte("t4_byte3", 8'hA9);
    expect_byte("t4_byte4", 8'hAA);
    expect_byte("t4_byte5", 8'hAB);
    chk("t4_ovf_end", ovf, 0);

    // 5: async reset in data bit 3 of 0xA7
    data_in = 4'h7;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    n = 0;
    while (Tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) timeout_fail("t5_wait_fall");
    repeat (4 * CPB + 6) @(negedge clk);
    chk("t5_bit3", Tx, 0);
    chk("t5_busy_mid", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tx", Tx, 1);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t5_no_frame", rx_q.size(), 0);
    chk("t5_tx_idle", Tx, 1);
    data_in = 4'h9;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle("t5_idle");
    expect_byte("t5_byte", 8'hA9);
    chk("t5_no_extra", rx_q.size(), 0);

    // 6: long idle
    idle_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (Tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    chk("t6_idle_clean", idle_bad, 0);
    chk("t6_no_bytes", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
